// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage ALU for the 5-stage MIPS pipeline.
// Decodes main-control ALU op and funct into a 4-bit ALU control code,
// computes the ALU result and zero flag, provides a free-standing adder
// for PC+4 / branch targets, and registers result/zero for EX/MEM.
module ex_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_b,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] add_sum,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q
);

  localparam logic [3:0] CtrlAnd     = 4'b0000;
  localparam logic [3:0] CtrlOr      = 4'b0001;
  localparam logic [3:0] CtrlAdd     = 4'b0010;
  localparam logic [3:0] CtrlSub     = 4'b0110;
  localparam logic [3:0] CtrlSlt     = 4'b0111;
  localparam logic [3:0] CtrlNor     = 4'b1100;
  localparam logic [3:0] CtrlInvalid = 4'b1111;

  localparam logic [WIDTH-1:0] SltTrue = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] result_d;
  logic             zero_d;

  // Translate the main-control op (and funct for R-type) into an ALU control code.
  always_comb begin
    alu_ctrl = CtrlInvalid;
    unique case (alu_op)
      3'b000: alu_ctrl = CtrlAdd;
      3'b001: alu_ctrl = CtrlSub;
      3'b010: begin
        unique case (funct)
          6'b100000: alu_ctrl = CtrlAdd;
          6'b100010: alu_ctrl = CtrlSub;
          6'b100100: alu_ctrl = CtrlAnd;
          6'b100101: alu_ctrl = CtrlOr;
          6'b101010: alu_ctrl = CtrlSlt;
          6'b100111: alu_ctrl = CtrlNor;
          default:   alu_ctrl = CtrlInvalid;
        endcase
      end
      3'b011:  alu_ctrl = CtrlAnd;
      3'b100:  alu_ctrl = CtrlOr;
      3'b101:  alu_ctrl = CtrlSlt;
      default: alu_ctrl = CtrlInvalid;
    endcase
  end

  // Evaluate the selected ALU function; unknown codes yield zero so the
  // downstream stages never see X.
  always_comb begin
    alu_result = '0;
    unique case (alu_ctrl)
      CtrlAnd: alu_result = in_a & in_b;
      CtrlOr:  alu_result = in_a | in_b;
      CtrlAdd: alu_result = in_a + in_b;
      CtrlSub: alu_result = in_a - in_b;
      CtrlSlt: alu_result = ($signed(in_a) < $signed(in_b)) ? SltTrue : '0;
      CtrlNor: alu_result = ~(in_a | in_b);
      default: alu_result = '0;
    endcase
  end

  assign zero    = (alu_result == '0);
  assign add_sum = add_a + add_b;

  assign result_d = alu_result;
  assign zero_d   = zero;

  // EX/MEM pipeline register: captures every cycle, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// tb_ex_alu_unit: directed and randomized checks of ex_alu_unit against a
// behavioural model derived from the ALU op / funct tables.
module tb_ex_alu_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] add_sum;
  logic [31:0] result_q;
  logic        zero_q;

  int vectors = 0;
  int misses  = 0;

  logic [31:0] expRes;
  logic        expZero;

  ex_alu_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_op     (alu_op),
    .funct      (funct),
    .in_a       (in_a),
    .in_b       (in_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .zero       (zero),
    .add_sum    (add_sum),
    .result_q   (result_q),
    .zero_q     (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: which operation a given op/funct pair names.
  function automatic logic [3:0] refCtrl(input logic [2:0] op, input logic [5:0] fn);
    case (op)
      3'd0: return 4'b0010;
      3'd1: return 4'b0110;
      3'd2: begin
        if (fn == 6'h20) return 4'b0010;
        if (fn == 6'h22) return 4'b0110;
        if (fn == 6'h24) return 4'b0000;
        if (fn == 6'h25) return 4'b0001;
        if (fn == 6'h2A) return 4'b0111;
        if (fn == 6'h27) return 4'b1100;
        return 4'b1111;
      end
      3'd3: return 4'b0000;
      3'd4: return 4'b0001;
      3'd5: return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  // Reference: arithmetic done with wide integers and truncated mod 2^32.
  function automatic logic [31:0] refAlu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint ua;
    longint ub;
    int     sa;
    int     sb;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = int'(a);
    sb = int'(b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return 32'((ua + ub) % 64'sh1_0000_0000);
      4'b0110: return 32'((ua - ub + 64'sh1_0000_0000) % 64'sh1_0000_0000);
      4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [5:0] fn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] aa, input logic [31:0] ab);
    alu_op = op;
    funct  = fn;
    in_a   = a;
    in_b   = b;
    add_a  = aa;
    add_b  = ab;
    #1;
  endtask

  // Compare all combinational outputs against the model; remember result for the register check.
  task automatic checkOutput(input string tag);
    logic [3:0]  c;
    logic [31:0] r;
    logic [31:0] s;
    c = refCtrl(alu_op, funct);
    r = refAlu(c, in_a, in_b);
    s = 32'((longint'({32'b0, add_a}) + longint'({32'b0, add_b})) % 64'sh1_0000_0000);
    vectors++;
    assert (alu_ctrl === c) else begin
      misses++;
      $error("[TB] FAIL %s ctrl: observed %b expected %b", tag, alu_ctrl, c);
    end
    vectors++;
    assert (alu_result === r) else begin
      misses++;
      $error("[TB] FAIL %s result: observed %h expected %h", tag, alu_result, r);
    end
    vectors++;
    assert (zero === (r == 32'd0)) else begin
      misses++;
      $error("[TB] FAIL %s zero: observed %b expected %b", tag, zero, (r == 32'd0));
    end
    vectors++;
    assert (add_sum === s) else begin
      misses++;
      $error("[TB] FAIL %s add_sum: observed %h expected %h", tag, add_sum, s);
    end
    expRes  = r;
    expZero = (r == 32'd0);
  endtask

  task automatic checkReg(input string tag, input logic [31:0] er, input logic ez);
    vectors++;
    assert (result_q === er) else begin
      misses++;
      $error("[TB] FAIL %s result_q: observed %h expected %h", tag, result_q, er);
    end
    vectors++;
    assert (zero_q === ez) else begin
      misses++;
      $error("[TB] FAIL %s zero_q: observed %b expected %b", tag, zero_q, ez);
    end
  endtask

  task automatic checkExact(input string tag, input logic [31:0] want);
    vectors++;
    assert (alu_result === want) else begin
      misses++;
      $error("[TB] FAIL %s literal: observed %h expected %h", tag, alu_result, want);
    end
  endtask

  // Drive at the falling edge, check combinational outputs, then check the register after the next rising edge.
  task automatic step(input string tag, input logic [2:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] aa, input logic [31:0] ab);
    logic [31:0] r;
    logic        z;
    @(negedge clk);
    applyStimulus(op, fn, a, b, aa, ab);
    checkOutput(tag);
    r = expRes;
    z = expZero;
    @(posedge clk);
    #1;
    checkReg(tag, r, z);
  endtask

  logic [5:0] functList [7];

  initial begin
    functList = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00};
    reset = 1'b0;
    applyStimulus(3'd0, 6'd0, 32'd3, 32'd4, 32'd1, 32'd2);
    checkReg("reset_initial", 32'd0, 1'b0);
    checkOutput("comb_in_reset");
    @(negedge clk);
    reset = 1'b1;

    // Directed cases.
    step("rtype_add", 3'b010, 6'h20, 32'd5, 32'd7, 32'd0, 32'd0);
    checkExact("rtype_add_12", 32'd12);
    step("beq_sub_eq", 3'b001, 6'h00, 32'h1234, 32'h1234, 32'd0, 32'd0);
    step("nor_zero", 3'b010, 6'h27, 32'd0, 32'd0, 32'd0, 32'd0);
    checkExact("nor_ones", 32'hFFFF_FFFF);
    step("slti_neg", 3'b101, 6'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    checkExact("slti_neg_1", 32'd1);
    step("slti_pos", 3'b101, 6'h00, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);
    checkExact("slti_pos_0", 32'd0);
    step("slt_ovf", 3'b010, 6'h2A, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd0);
    checkExact("slt_ovf_1", 32'd1);
    step("add_wrap", 3'b000, 6'h00, 32'hFFFF_FFFF, 32'd1, 32'h0040_0000, 32'd4);
    step("add_max", 3'b000, 6'h00, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFC, 32'd8);
    checkExact("add_max_val", 32'h8000_0000);
    step("bad_funct", 3'b010, 6'h00, 32'd9, 32'd9, 32'd0, 32'd0);
    step("bad_op7", 3'b111, 6'h20, 32'd9, 32'd9, 32'd0, 32'd0);
    step("bad_op6", 3'b110, 6'h20, 32'd1, 32'd2, 32'd0, 32'd0);
    step("andi", 3'b011, 6'h00, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'd0);
    step("ori", 3'b100, 6'h00, 32'hF000_0000, 32'h0000_000F, 32'd0, 32'd0);

    // Asynchronous reset between clock edges.
    step("load_55", 3'b000, 6'h00, 32'h50, 32'h5, 32'd0, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkReg("async_reset", 32'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkReg("post_release_hold", 32'd0, 1'b0);
    @(posedge clk);
    #1;
    checkReg("post_release_capture", 32'h55, 1'b0);

    // Randomized sweep.
    for (int i = 0; i < 300; i++) begin
      logic [2:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functList[$urandom_range(0, 6)];
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = a;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      step("random", op, fn, a, b, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
